seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse-direction companion to the shift-add multiplier datapath.
- Accepts an 8-bit dividend and an 8-bit divisor on a Run pulse/level. It produces quotient and remainder after one load cycle plus WIDTH iteration cycles.
- It is a standalone arithmetic unit that sits beside the multiplier. Its operands come from switch/register inputs, and its results drive the hex displays.
- Each iteration performs one trial subtraction through an internal add/sub (fn fixed to subtract) and restores on a negative result.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits. The iteration counter is clog2(WIDTH)+1 bits wide.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Run  input  1  start request, sampled only in IDLE; level-sensitive (button-style)
- A  input  WIDTH  dividend, unsigned
- B  input  WIDTH  divisor, unsigned
- Q  output  WIDTH  quotient (working register; valid only while Done=1)
- R  output  WIDTH  remainder (working register; valid only while Done=1)
- Busy  output  1  high in CALC
- Done  output  1  high in DONE
- DivZero  output  1  high in DONE when the operation had B==0; cleared on the next load

Behaviour:
- Reset (async, any state, including mid-operation):
  - State returns to IDLE immediately.
  - Q, R, the divisor register and the counter are cleared to 0.
  - Busy, Done and DivZero go to 0.
- States: IDLE, CALC, DONE. Registered outputs only; Busy=(state==CALC), Done=(state==DONE).
- IDLE:
  - Hold all registers.
  - On an edge with Run=1: Q<=A, R<=0, Dreg<=B, cnt<=0, DivZero<=(B==0).
  - If B!=0, go to CALC. If B==0, go to DONE with Q<=all ones and R<=A (short-circuit, 1 edge).
- CALC, each edge:
  - P = {R, Q[WIDTH-1]} (WIDTH+1 bits).
  - T = P - {0, Dreg}, computed in WIDTH+2-bit two's complement.
  - If T is non-negative: R<=T[WIDTH-1:0], Q<={Q[WIDTH-2:0],1}.
  - Otherwise: R<=P[WIDTH-1:0], Q<={Q[WIDTH-2:0],0}.
  - cnt<=cnt+1. When cnt==WIDTH-1 on this edge, go to DONE.
  - The restored value always fits in WIDTH bits because P<Dreg<=2^WIDTH-1.
- Latency:
  - Run sampled at load edge 0.
  - WIDTH CALC edges follow.
  - Done=1 after edge WIDTH+1 (9 edges for WIDTH=8). For B==0, Done=1 after edge 1.
- DONE:
  - Hold Q, R and DivZero.
  - Stay while Run=1, so a held button never restarts the operation.
  - When Run=0, go to IDLE on that edge; Done clears and Q/R keep their values.
- Run during CALC is ignored.
- Changes on A/B after the load edge are ignored (operands are captured in Q/Dreg).
- Q/R values seen during CALC are intermediate and must not be checked.
- For a nonzero divisor, A == Q*B + R and R < B.

Test Plan:
- A=100, B=7, Run pulsed 1 cycle → Busy for 8 cycles, then Done=1 after the 9th edge with Q=14, R=2, DivZero=0.
- Edge operands (each run separately):
  - A=255, B=1 → Q=255, R=0.
  - A=0, B=5 → Q=0, R=0.
  - A=200, B=201 → Q=0, R=200.
  - A=255, B=255 → Q=1, R=0.
- A=37, B=0 → after 1 edge: Done=1, DivZero=1, Q=8'hFF, R=37, Busy never asserted. A following A=9, B=3 run clears DivZero and gives Q=3, R=0.
- Run held high for 20 cycles with A=50, B=6 → a single operation runs, Done stays 1 with Q=8, R=2. Run low → IDLE next edge. Run high again → a new operation starts.
- Mid-operation stimulus: A/B changed to 13/4 during CALC and Run toggled in CALC → result still from the original 100/7 (Q=14, R=2); no restart occurs.
- Reset pulsed asynchronously (between edges) at the 4th CALC cycle → Q=R=0 and Busy=Done=DivZero=0 immediately. A subsequent Run with 81/9 completes normally with Q=9, R=0.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock after a load cycle.
// state  | meaning
// IDLE   | waiting for Run; registers hold the last result
// CALC   | WIDTH shift / trial-subtract iterations
// DONE   | result valid; stays until Run is released
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dreg_q, dreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH:0]   p;
    logic [WIDTH+1:0] t;
    logic             t_neg;
    logic             t_unused;

    // Trial subtraction: the add/sub unit with its function fixed to subtract.
    assign p        = {r_q, q_q[WIDTH-1]};
    assign t        = {1'b0, p} - {2'b00, dreg_q};
    assign t_neg    = t[WIDTH+1];
    assign t_unused = t[WIDTH];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            q_q       <= '0;
            r_q       <= '0;
            dreg_q    <= '0;
            cnt_q     <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dreg_q    <= dreg_d;
            cnt_q     <= cnt_d;
            divzero_q <= divzero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        r_d       = r_q;
        dreg_d    = dreg_q;
        cnt_d     = cnt_q;
        divzero_d = divzero_q;
        unique case (state_q)
            S_IDLE: begin
                if (Run) begin
                    dreg_d    = B;
                    cnt_d     = '0;
                    divzero_d = (B == '0);
                    if (B == '0) begin
                        // Divide by zero short-circuits straight to DONE.
                        q_d     = '1;
                        r_d     = A;
                        state_d = S_DONE;
                    end else begin
                        q_d     = A;
                        r_d     = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (t_neg) begin
                    r_d = p[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end else begin
                    r_d = t[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_q == S_CALC);
        Done    = (state_q == S_DONE);
        DivZero = divzero_q;
        Q       = q_q;
        R       = r_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized operands
// checked against plain integer division.
module tb_seq_divider;
    logic       Clk;
    logic       Reset;
    logic       Run;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .A(A), .B(B),
        .Q(Q), .R(R), .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void ref_div(input int a, input int b, output int eq, output int er);
        if (b == 0) begin
            eq = 255;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
    endfunction

    // Presents operands with a one-cycle Run pulse; returns at the falling edge after the load edge.
    task automatic start_op(input int a, input int b);
        @(negedge Clk);
        A   = 8'(a);
        B   = 8'(b);
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
    endtask

    // Counts Busy samples until Done, bounded by a cycle budget.
    task automatic wait_done(output int busy_cnt, output bit seen);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        Run   = 1'b0;
        A     = 8'd0;
        B     = 8'd0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Q, R, Busy, Done, DivZero} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d Busy=%b Done=%b DivZero=%b, expected all 0",
                     Q, R, Busy, Done, DivZero);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got Busy=%b Done=%b, expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_basic;
        int  bc;
        bit  seen;
        start_op(100, 7);
        wait_done(bc, seen);
        checks++;
        if (!seen || bc != 8) begin
            errors++;
            $display("FAIL basic_latency: got done=%b busy_cycles=%0d, expected 1 8", seen, bc);
        end
        checks++;
        if (Q !== 8'd14 || R !== 8'd2 || DivZero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got Q=%0d R=%0d DZ=%b, expected 14 2 0", Q, R, DivZero);
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Q !== 8'd14 || R !== 8'd2) begin
            errors++;
            $display("FAIL basic_idle_hold: got Done=%b Busy=%b Q=%0d R=%0d, expected 0 0 14 2",
                     Done, Busy, Q, R);
        end
    endtask

    task automatic test_edges;
        int ta[4] = '{255, 0, 200, 255};
        int tb[4] = '{1, 5, 201, 255};
        int eq, er, bc;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            ref_div(ta[i], tb[i], eq, er);
            start_op(ta[i], tb[i]);
            wait_done(bc, seen);
            checks++;
            if (!seen || bc != 8 || Q !== 8'(eq) || R !== 8'(er) || DivZero !== 1'b0) begin
                errors++;
                $display("FAIL edge_%0d_%0d: got done=%b busy=%0d Q=%0d R=%0d DZ=%b, expected 1 8 %0d %0d 0",
                         ta[i], tb[i], seen, bc, Q, R, DivZero, eq, er);
            end
        end
    endtask

    task automatic test_divzero;
        int bc;
        bit seen;
        start_op(37, 0);
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || DivZero !== 1'b1 || Q !== 8'hFF || R !== 8'd37) begin
            errors++;
            $display("FAIL divzero: got Done=%b Busy=%b DZ=%b Q=%h R=%0d, expected 1 0 1 ff 37",
                     Done, Busy, DivZero, Q, R);
        end
        start_op(9, 3);
        checks++;
        if (DivZero !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL divzero_clear: got DZ=%b Busy=%b after load, expected 0 1", DivZero, Busy);
        end
        wait_done(bc, seen);
        checks++;
        if (!seen || Q !== 8'd3 || R !== 8'd0 || DivZero !== 1'b0) begin
            errors++;
            $display("FAIL divzero_next: got done=%b Q=%0d R=%0d DZ=%b, expected 1 3 0 0",
                     seen, Q, R, DivZero);
        end
    endtask

    task automatic test_run_held;
        int bc = 0;
        int dc = 0;
        bit dropped = 1'b0;
        int bc2;
        bit seen;
        @(negedge Clk);
        A   = 8'd50;
        B   = 8'd6;
        Run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Busy) bc++;
            if (Done) dc++;
            else if (dc > 0) dropped = 1'b1;
        end
        checks++;
        if (bc != 8 || dc != 12 || dropped) begin
            errors++;
            $display("FAIL held_single_op: got busy=%0d done=%0d dropped=%b, expected 8 12 0", bc, dc, dropped);
        end
        checks++;
        if (Q !== 8'd8 || R !== 8'd2) begin
            errors++;
            $display("FAIL held_result: got Q=%0d R=%0d, expected 8 2", Q, R);
        end
        Run = 1'b0;
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL held_release: got Done=%b Busy=%b, expected 0 0", Done, Busy);
        end
        A   = 8'd77;
        B   = 8'd10;
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: got Busy=%b, expected 1", Busy);
        end
        wait_done(bc2, seen);
        checks++;
        if (!seen || Q !== 8'd7 || R !== 8'd7) begin
            errors++;
            $display("FAIL held_second: got done=%b Q=%0d R=%0d, expected 1 7 7", seen, Q, R);
        end
    endtask

    task automatic test_mid_op;
        int bc;
        bit seen;
        start_op(100, 7);
        @(negedge Clk);
        A   = 8'd13;
        B   = 8'd4;
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        wait_done(bc, seen);
        checks++;
        if (!seen || bc != 4 || Q !== 8'd14 || R !== 8'd2) begin
            errors++;
            $display("FAIL mid_op: got done=%b busy_rest=%0d Q=%0d R=%0d, expected 1 4 14 2",
                     seen, bc, Q, R);
        end
    endtask

    task automatic test_async_reset;
        int bc;
        bit seen;
        start_op(100, 7);
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Q, R, Busy, Done, DivZero} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got Q=%0d R=%0d Busy=%b Done=%b DZ=%b, expected all 0",
                     Q, R, Busy, Done, DivZero);
        end
        #1 Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_idle: got Busy=%b Done=%b, expected 0 0", Busy, Done);
        end
        start_op(81, 9);
        wait_done(bc, seen);
        checks++;
        if (!seen || bc != 8 || Q !== 8'd9 || R !== 8'd0) begin
            errors++;
            $display("FAIL after_reset: got done=%b busy=%0d Q=%0d R=%0d, expected 1 8 9 0", seen, bc, Q, R);
        end
    endtask

    task automatic test_random;
        int a, b, eq, er, bc, ebc;
        bit seen;
        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            ref_div(a, b, eq, er);
            ebc = (b == 0) ? 0 : 8;
            start_op(a, b);
            wait_done(bc, seen);
            checks++;
            if (!seen || bc != ebc || Q !== 8'(eq) || R !== 8'(er) || DivZero !== (b == 0)) begin
                errors++;
                $display("FAIL random_%0d_%0d: got done=%b busy=%0d Q=%0d R=%0d DZ=%b, expected 1 %0d %0d %0d %0d",
                         a, b, seen, bc, Q, R, DivZero, ebc, eq, er, (b == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_divzero();
        test_run_held();
        test_mid_op();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
